player_link_tx: RTL and testbench

PLAYER_LINK_TX -- requirements
Module: player_link_tx

---
 rtl/player_link_tx.sv | 99 +++++++++
 tb/tb_player_link_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_link_tx.sv
// Serial transmitter for the inter-board player link: frames a 16-bit payload
// (x position, game state, start request, even parity) as start/data/stop bits.
module player_link_tx #(
   parameter int unsigned CLK_DIV = 650
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_valid,
   input  logic [11:0] xpos_player,
   input  logic [1:0]  game_state,   // g_state code: START=0, LEVEL_1=1, FINISH=2
   input  logic        start_req,
   output logic        tx_ready,
   output logic        gpio_tx,
   output logic        frame_done
);

   localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA      = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [15:0] cnt;
   logic [3:0]  bit_idx;
   logic [15:0] shreg;
   logic [15:0] payload;
   logic        bit_end;
   logic        accept;
   logic        gpio_nx;
   logic        done_nx;

   always_comb begin
      payload[14:0] = {start_req, game_state, xpos_player};
      payload[15]   = ^payload[14:0];
      bit_end       = (cnt == '0);
      accept        = (state == IDLE) && tx_valid;
      tx_ready      = (state == IDLE);
   end

   // State register plus bit timer and shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         gpio_tx    <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         gpio_tx    <= gpio_nx;
         frame_done <= done_nx;

         if (state_nx == IDLE)
            cnt <= '0;
         else if (state == IDLE || bit_end)
            cnt <= RELOAD;
         else
            cnt <= cnt - 16'd1;

         if (accept) begin
            shreg   <= payload;
            bit_idx <= '0;
         end else if (state == DATA && bit_end && bit_idx != 4'd15) begin
            shreg   <= {1'b0, shreg[15:1]};
            bit_idx <= bit_idx + 4'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (tx_valid) state_nx = START_BIT;
         START_BIT: if (bit_end) state_nx = DATA;
         DATA:      if (bit_end && bit_idx == 4'd15) state_nx = STOP_BIT;
         STOP_BIT:  if (bit_end) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // shreg[0] is the bit on the line during DATA; at a bit boundary the next
   // bit is shreg[1] since the shift lands on the same edge as gpio_tx.
   always_comb begin
      gpio_nx = 1'b1;
      done_nx = (state == STOP_BIT) && (state_nx == IDLE);
      case (state_nx)
         START_BIT: gpio_nx = 1'b0;
         DATA:      gpio_nx = (state == DATA && bit_end) ? shreg[1] : shreg[0];
         default:   gpio_nx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_player_link_tx.sv
// Self-checking bench for player_link_tx: table-driven frames, random frames
// against a payload/line model, plus back-to-back, reset-abort and ignore cases.
`timescale 1ns/1ps
module tb_player_link_tx;

   localparam int C = 4;
   localparam int FRAME = 18 * C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_valid = 1'b0;
   logic [11:0] xpos_player = '0;
   logic [1:0]  game_state = '0;
   logic        start_req = 1'b0;
   logic        tx_ready;
   logic        gpio_tx;
   logic        frame_done;

   int vectors = 0;
   int miscompares = 0;

   player_link_tx #(.CLK_DIV(C)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_valid    (tx_valid),
      .xpos_player (xpos_player),
      .game_state  (game_state),
      .start_req   (start_req),
      .tx_ready    (tx_ready),
      .gpio_tx     (gpio_tx),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] xpos;
      logic [1:0]  gs;
      logic        sr;
      logic [15:0] exp_payload;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Payload from its field rules using plain arithmetic
   function automatic logic [15:0] model_payload(input int x, input int gs, input int sr);
      int v;
      v = x + gs * 4096 + sr * 16384;
      if ($countones(v) % 2 == 1) v += 32768;
      return 16'(v);
   endfunction

   function automatic logic frame_bit(input logic [15:0] p, input int b);
      if (b == 0) return 1'b0;
      if (b == 17) return 1'b1;
      return p[b-1];
   endfunction

   task automatic start_frame(input logic [11:0] x, input logic [1:0] gs,
                              input logic sr, input bit hold);
      int n;
      n = 0;
      while (tx_ready !== 1'b1 && n < 200) begin
         tick;
         n++;
      end
      chk("ready_before_send", 32'(tx_ready), 32'd1);
      xpos_player = x;
      game_state  = gs;
      start_req   = sr;
      tx_valid    = 1'b1;
      tick;
      chk("ready_drop", 32'(tx_ready), 32'd0);
      if (!hold) tx_valid = 1'b0;
      xpos_player = 12'($urandom);
      game_state  = 2'($urandom_range(0, 2));
      start_req   = 1'($urandom);
   endtask

   // Called in the first start-bit cycle; returns in the frame_done cycle
   task automatic check_frame(input logic [15:0] exp, input string name, input int pulse_at);
      logic [17:0] bad;
      logic [15:0] got;
      bit busy_ok;
      bit done_low;
      int b;
      bad = '0;
      got = '0;
      busy_ok = 1;
      done_low = 1;
      for (int i = 0; i < FRAME; i++) begin
         b = i / C;
         if (gpio_tx !== frame_bit(exp, b)) bad[b] = 1'b1;
         if (i % C == C / 2 && b >= 1 && b <= 16) got[b-1] = gpio_tx;
         if (tx_ready !== 1'b0) busy_ok = 0;
         if (frame_done !== 1'b0) done_low = 0;
         if (pulse_at >= 0 && i == pulse_at) begin
            tx_valid    = 1'b1;
            xpos_player = ~xpos_player;
         end else if (pulse_at >= 0 && i == pulse_at + 1) begin
            tx_valid = 1'b0;
         end
         tick;
      end
      chk({name, "_bit_errors"}, 32'(bad), 32'd0);
      chk({name, "_payload"}, 32'(got), 32'(exp));
      chk({name, "_busy"}, 32'(busy_ok), 32'd1);
      chk({name, "_done_low"}, 32'(done_low), 32'd1);
      chk({name, "_frame_done"}, 32'(frame_done), 32'd1);
      chk({name, "_ready_at_done"}, 32'(tx_ready), 32'd1);
      chk({name, "_line_idle"}, 32'(gpio_tx), 32'd1);
   endtask

   vec_t table_v[4];

   initial begin
      logic [15:0] e;
      logic [11:0] rx;
      logic [1:0]  rg;
      logic        rs;
      bit          idle_ok;

      table_v[0] = '{12'h3D4, 2'd1, 1'b0, 16'h93D4};
      table_v[1] = '{12'h000, 2'd0, 1'b1, 16'hC000};
      table_v[2] = '{12'hFFF, 2'd2, 1'b0, 16'hAFFF};
      table_v[3] = '{12'h555, 2'd0, 1'b1, 16'hC555};

      // Reset state, held across an edge
      tick;
      chk("rst_gpio", 32'(gpio_tx), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_done", 32'(frame_done), 32'd0);
      rst = 1'b0;

      idle_ok = 1;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (gpio_tx !== 1'b1 || tx_ready !== 1'b1 || frame_done !== 1'b0) idle_ok = 0;
      end
      chk("idle_100", 32'(idle_ok), 32'd1);

      foreach (table_v[k]) begin
         start_frame(table_v[k].xpos, table_v[k].gs, table_v[k].sr, 0);
         check_frame(table_v[k].exp_payload, $sformatf("table%0d", k), -1);
         tick;
      end

      // Back-to-back with tx_valid held; second frame accepted on frame_done cycle
      start_frame(12'hFFF, 2'd2, 1'b0, 1);
      xpos_player = 12'h001;
      game_state  = 2'd2;
      start_req   = 1'b0;
      check_frame(model_payload(12'hFFF, 2, 0), "b2b_first", -1);
      tick;
      chk("b2b_start_bit", 32'(gpio_tx), 32'd0);
      chk("b2b_ready_low", 32'(tx_ready), 32'd0);
      tx_valid = 1'b0;
      check_frame(model_payload(12'h001, 2, 0), "b2b_second", -1);
      tick;

      // Reset during payload bit 7
      e = model_payload(12'h2A7, 1, 1);
      start_frame(12'h2A7, 2'd1, 1'b1, 0);
      for (int i = 0; i < 8 * C + 1; i++) tick;
      chk("pre_rst_bit7", 32'(gpio_tx), 32'(e[7]));
      #2 rst = 1'b1;
      #1;
      chk("async_rst_gpio", 32'(gpio_tx), 32'd1);
      chk("async_rst_ready", 32'(tx_ready), 32'd1);
      chk("async_rst_done", 32'(frame_done), 32'd0);
      for (int i = 0; i < 3; i++) tick;
      chk("rst_hold_gpio", 32'(gpio_tx), 32'd1);
      xpos_player = 12'h0C3;
      game_state  = 2'd0;
      start_req   = 1'b0;
      tx_valid    = 1'b1;
      #2 rst = 1'b0;
      tick;
      chk("first_edge_accept", 32'(tx_ready), 32'd0);
      tx_valid = 1'b0;
      check_frame(model_payload(12'h0C3, 0, 0), "after_rst", -1);
      tick;

      // tx_valid pulse during DATA must be ignored, with nothing queued
      start_frame(12'h7E1, 2'd1, 1'b0, 0);
      check_frame(model_payload(12'h7E1, 1, 0), "ignore", 40);
      idle_ok = 1;
      for (int i = 0; i < 2 * C; i++) begin
         tick;
         if (gpio_tx !== 1'b1 || tx_ready !== 1'b1) idle_ok = 0;
      end
      chk("no_queued_frame", 32'(idle_ok), 32'd1);

      // Randomized frames against the model
      for (int r = 0; r < 8; r++) begin
         rx = 12'($urandom_range(0, 4095));
         rg = 2'($urandom_range(0, 2));
         rs = 1'($urandom_range(0, 1));
         e  = model_payload(int'(rx), int'(rg), int'(rs));
         start_frame(rx, rg, rs, 0);
         check_frame(e, $sformatf("rand%0d", r), -1);
         if (r % 2 == 1) tick;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
